video_timing_gen: RTL

//  Raster timing source sitting directly upstream of videogen. Produces counterX/counterY,
//  the field flag 'state' (drives videogen's v_total_1/v_total_2 selection) and the

---
 rtl/video_timing_gen.sv | 135 +++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing source: pixel/line counters, field flag, registered hsync/vsync and a
// mode shadow that is committed only on a frame boundary so the raster never tears.
module video_timing_gen #(
  parameter logic [11:0] DEF_H_ACTIVE   = 12'd1280,
  parameter logic [11:0] DEF_H_SYNC_S   = 12'd1390,
  parameter logic [11:0] DEF_H_SYNC_E   = 12'd1430,
  parameter logic [11:0] DEF_H_TOTAL    = 12'd1650,
  parameter logic [11:0] DEF_V_ACTIVE   = 12'd720,
  parameter logic [11:0] DEF_V_SYNC_S   = 12'd725,
  parameter logic [11:0] DEF_V_SYNC_E   = 12'd730,
  parameter logic [11:0] DEF_V_TOTAL_1  = 12'd750,
  parameter logic [11:0] DEF_V_TOTAL_2  = 12'd750,
  parameter logic        DEF_INTERLACED = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mode_load,
  input  logic [11:0] mode_h_active,
  input  logic [11:0] mode_h_sync_s,
  input  logic [11:0] mode_h_sync_e,
  input  logic [11:0] mode_h_total,
  input  logic [11:0] mode_v_active,
  input  logic [11:0] mode_v_sync_s,
  input  logic [11:0] mode_v_sync_e,
  input  logic [11:0] mode_v_total_1,
  input  logic [11:0] mode_v_total_2,
  input  logic        mode_interlaced,
  output logic        mode_reject,
  output logic        mode_pending,
  output logic [11:0] counterX,
  output logic [11:0] counterY,
  output logic        state,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  typedef struct packed {
    logic [11:0] h_sync_s, h_sync_e, h_total;
    logic [11:0] v_sync_s, v_sync_e, v_total_1, v_total_2;
    logic        interlaced;
  } timing_t;

  localparam timing_t DEF_MODE = '{
    h_sync_s: DEF_H_SYNC_S, h_sync_e: DEF_H_SYNC_E, h_total: DEF_H_TOTAL,
    v_sync_s: DEF_V_SYNC_S, v_sync_e: DEF_V_SYNC_E,
    v_total_1: DEF_V_TOTAL_1, v_total_2: DEF_V_TOTAL_2, interlaced: DEF_INTERLACED};

  localparam logic [11:0] DEF_V_LIMIT =
    (DEF_INTERLACED && DEF_V_TOTAL_2 < DEF_V_TOTAL_1) ? DEF_V_TOTAL_2 : DEF_V_TOTAL_1;

  // The reset-time mode must obey the same rule as a loaded one.
  if (!(DEF_H_ACTIVE < DEF_H_SYNC_S && DEF_H_SYNC_S < DEF_H_SYNC_E &&
        DEF_H_SYNC_E <= DEF_H_TOTAL && DEF_H_TOTAL >= 12'd16 &&
        DEF_V_ACTIVE < DEF_V_SYNC_S && DEF_V_SYNC_S < DEF_V_SYNC_E &&
        DEF_V_SYNC_E < DEF_V_LIMIT)) begin : g_bad_defaults
    $error("video_timing_gen: DEF_* parameters describe an invalid mode");
  end

  timing_t     act, shadow, load_mode;
  logic [11:0] v_limit, v_total_f, half_line;
  logic [11:0] nx, ny;
  logic        nf, load_ok, x_last, y_last, field_next, boundary, commit;
  logic        h_in, v_in, v_after_start, v_before_end;

  assign load_mode = '{
    h_sync_s: mode_h_sync_s, h_sync_e: mode_h_sync_e, h_total: mode_h_total,
    v_sync_s: mode_v_sync_s, v_sync_e: mode_v_sync_e,
    v_total_1: mode_v_total_1, v_total_2: mode_v_total_2, interlaced: mode_interlaced};

  // mode_load is a single-cycle strobe with no back-pressure: every strobe is either
  // accepted into the shadow (mode_pending) or answered with a one-cycle mode_reject.
  assign v_limit = (mode_interlaced && mode_v_total_2 < mode_v_total_1) ?
                   mode_v_total_2 : mode_v_total_1;
  assign load_ok = (mode_h_active < mode_h_sync_s) && (mode_h_sync_s < mode_h_sync_e) &&
                   (mode_h_sync_e <= mode_h_total) && (mode_h_total >= 12'd16) &&
                   (mode_v_active < mode_v_sync_s) && (mode_v_sync_s < mode_v_sync_e) &&
                   (mode_v_sync_e < v_limit);

  assign v_total_f  = state ? act.v_total_2 : act.v_total_1;
  assign x_last     = counterX >= act.h_total - 12'd1;
  assign y_last     = counterY >= v_total_f - 12'd1;
  assign field_next = act.interlaced & ~state;
  assign boundary   = x_last & y_last & ~field_next;
  assign commit     = boundary & mode_pending;

  always_comb begin
    nx = counterX + 12'd1;
    ny = counterY;
    nf = state;
    if (x_last) begin
      nx = 12'd0;
      ny = y_last ? 12'd0 : counterY + 12'd1;
      if (y_last) nf = field_next;
    end
  end

  // Field 1 of an interlaced mode places both vsync edges half a line later.
  assign half_line     = act.h_total >> 1;
  assign v_after_start = (counterY > act.v_sync_s) ||
                         (counterY == act.v_sync_s && counterX >= half_line);
  assign v_before_end  = (counterY < act.v_sync_e) ||
                         (counterY == act.v_sync_e && counterX < half_line);
  assign h_in = (counterX >= act.h_sync_s) && (counterX < act.h_sync_e);
  assign v_in = (act.interlaced && state) ? (v_after_start && v_before_end) :
                ((counterY >= act.v_sync_s) && (counterY < act.v_sync_e));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counterX     <= 12'd0;
      counterY     <= 12'd0;
      state        <= 1'b0;
      hsync        <= 1'b0;
      vsync        <= 1'b0;
      frame_start  <= 1'b0;
      mode_reject  <= 1'b0;
      mode_pending <= 1'b0;
      act          <= DEF_MODE;
      shadow       <= DEF_MODE;
    end else begin
      counterX     <= nx;
      counterY     <= ny;
      state        <= nf;
      hsync        <= h_in;
      vsync        <= v_in;
      frame_start  <= (nx == 12'd0) && (ny == 12'd0) && !nf;
      mode_reject  <= mode_load & ~load_ok;
      // Commit takes the shadow as it stood before this edge; a same-cycle load waits.
      if (commit) act <= shadow;
      if (mode_load && load_ok) shadow <= load_mode;
      mode_pending <= (mode_load & load_ok) | (mode_pending & ~commit);
    end
  end

endmodule
